k_wptr_gen: RTL and testbench

Write-domain pointer generator for the dual-clock FIFO. It is the stage directly upstream of the registered write-full flag, which compares this block's `wptr` against this block's `wq2_rptr`. The block does the following in the write clock domain:
- accepts write requests and drives the memory write enable and address;
- keeps the binary and Gray write pointers;
- synchronises the read-domain Gray pointer with two flops;
- reports fill level and almost-full.

---
 rtl/k_wptr_gen.sv | 129 ++++++++++++
 tb/tb_k_wptr_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/k_wptr_gen.sv
// k_wptr_gen - write-domain pointer generator for the dual-clock FIFO.
//
// Accepts write requests, drives the memory write enable and address, keeps
// the binary and Gray write pointers, brings the read-domain Gray pointer
// across with a two-flop synchroniser, and reports a registered fill level
// and almost-full flag. Level and flags are pessimistic because the read
// pointer they use is always stale by the synchroniser latency.
//
// Optional feature: define K_WPTR_OVF_EN to build the sticky overflow flag.
// Without it, woverflow is a constant 0.
//
// Parameters:
//   addr_size      address width, FIFO depth is 2**addr_size
//   almost_margin  walmost_full asserts when free slots <= almost_margin
//
// Ports:
//   wclk          in   write-domain clock
//   wrst_n        in   asynchronous active-low reset
//   winc          in   write request
//   wfull         in   registered full flag from the downstream full stage
//   rptr          in   read-domain Gray pointer (asynchronous to wclk)
//   wen           out  memory write enable (combinational)
//   waddr         out  memory write address
//   wptr          out  registered Gray write pointer
//   wq2_rptr      out  read pointer after the two-flop synchroniser
//   wlevel        out  registered fill level, 0..2**addr_size
//   walmost_full  out  registered almost-full flag
//   woverflow     out  sticky overflow flag (write attempted while full)

module k_wptr_gen #(
  parameter int addr_size     = 4,
  parameter int almost_margin = 2
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 winc,
  input  logic                 wfull,
  input  logic [addr_size:0]   rptr,
  output logic                 wen,
  output logic [addr_size-1:0] waddr,
  output logic [addr_size:0]   wptr,
  output logic [addr_size:0]   wq2_rptr,
  output logic [addr_size:0]   wlevel,
  output logic                 walmost_full,
  output logic                 woverflow
);

  localparam logic [addr_size:0] depth =
    (addr_size+1)'(1 << addr_size);
  localparam logic [addr_size:0] almost_thresh =
    (addr_size+1)'((1 << addr_size) - almost_margin);

  logic [addr_size:0] wbin;
  logic [addr_size:0] wbin_next;
  logic [addr_size:0] wq1_rptr;
  logic [addr_size:0] rq2bin;
  logic [addr_size:0] lvl_now;
  logic [addr_size:0] lvl_next;
  logic               full_now;

  // Gray to binary, walking from the MSB down.
  function automatic logic [addr_size:0] gray2bin(input logic [addr_size:0] g);
    logic [addr_size:0] b;
    b[addr_size] = g[addr_size];
    for (int i = addr_size - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign rq2bin   = gray2bin(wq2_rptr);
  assign lvl_now  = wbin - rq2bin;

  // The registered wfull lags wptr by a cycle; full_now closes that gap so
  // a write can never land on a slot the reader has not freed yet.
  assign full_now = (lvl_now == depth);

  // Gating with wrst_n keeps the memory quiet while reset is held.
  assign wen      = wrst_n & winc & ~wfull & ~full_now;
  assign waddr    = wbin[addr_size-1:0];

  assign wbin_next = wen ? wbin + 1'b1 : wbin;

  // Level uses the new write count against the old synchronised read count,
  // so it can only over-report.
  assign lvl_next  = wbin_next - rq2bin;

  // Write pointer state and registered level/flag.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= (wbin_next >> 1) ^ wbin_next;
      wlevel       <= lvl_next;
      walmost_full <= (lvl_next >= almost_thresh);
    end
  end

  // Two-flop synchroniser for the read pointer; nothing may sit between the
  // flops, and only a Gray-coded bus is safe to cross this way.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq1_rptr <= '0;
      wq2_rptr <= '0;
    end else begin
      wq1_rptr <= rptr;
      wq2_rptr <= wq1_rptr;
    end
  end

`ifdef K_WPTR_OVF_EN
  // Sticky record of any write request that was refused because the FIFO
  // was full; cleared only by reset.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      woverflow <= 1'b0;
    end else begin
      woverflow <= woverflow | (winc & (wfull | full_now));
    end
  end
`else
  assign woverflow = 1'b0;
`endif

endmodule

// File: tb/tb_k_wptr_gen.sv
// tb_k_wptr_gen - self-checking bench for k_wptr_gen (default parameters).
//
// A driver applies directed inputs on the falling edge and pushes the
// hand-computed expected outputs into a scoreboard queue. A monitor drains
// the queue a little after each falling edge and compares against the DUT.

module tb_k_wptr_gen;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic       wfull;
  logic [4:0] rptr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic [4:0] wq2_rptr;
  logic [4:0] wlevel;
  logic       walmost_full;
  logic       woverflow;

  typedef enum int {S_WEN, S_WADDR, S_WPTR, S_WQ2, S_WLEVEL, S_ALMOST, S_OVF} sel_e;
  typedef struct {
    sel_e        sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef K_WPTR_OVF_EN
  localparam logic ovf_exp = 1'b1;
`else
  localparam logic ovf_exp = 1'b0;
`endif

  // Gray code of the first 17 write counts, worked out by hand.
  logic [4:0] fill_gray [0:16] = '{5'd0, 5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4,
                                   5'd12, 5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9,
                                   5'd8, 5'd24};

  k_wptr_gen #(.addr_size(4), .almost_margin(2)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wfull        (wfull),
    .rptr         (rptr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wq2_rptr     (wq2_rptr),
    .wlevel       (wlevel),
    .walmost_full (walmost_full),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic applyStimulus(input logic rst_v, input logic inc_v,
                               input logic full_v, input logic [4:0] rptr_v);
    @(negedge wclk);
    wrst_n = rst_v;
    winc   = inc_v;
    wfull  = full_v;
    rptr   = rptr_v;
  endtask

  task automatic checkOutput(input sel_e sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic reportFail(input exp_t e, input logic [31:0] act);
    errors++;
    $display("[TB] FAIL %s: got %0d expected %0d at %0t", e.name, act, e.exp, $time);
  endtask

  // Monitor: compare everything expected for this cycle once the inputs
  // applied on the falling edge have settled.
  always @(negedge wclk) begin
    #2;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      case (e.sel)
        S_WEN:    if ({31'd0, wen} !== e.exp)          reportFail(e, {31'd0, wen});
        S_WADDR:  if ({28'd0, waddr} !== e.exp)        reportFail(e, {28'd0, waddr});
        S_WPTR:   if ({27'd0, wptr} !== e.exp)         reportFail(e, {27'd0, wptr});
        S_WQ2:    if ({27'd0, wq2_rptr} !== e.exp)     reportFail(e, {27'd0, wq2_rptr});
        S_WLEVEL: if ({27'd0, wlevel} !== e.exp)       reportFail(e, {27'd0, wlevel});
        S_ALMOST: if ({31'd0, walmost_full} !== e.exp) reportFail(e, {31'd0, walmost_full});
        default:  if ({31'd0, woverflow} !== e.exp)    reportFail(e, {31'd0, woverflow});
      endcase
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    wrst_n = 1'b0;
    winc   = 1'b1;
    wfull  = 1'b0;
    rptr   = 5'd0;

    // Reset held with a write request pending.
    repeat (2) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
      checkOutput(S_WEN,    0, "rst_wen");
      checkOutput(S_WPTR,   0, "rst_wptr");
      checkOutput(S_WLEVEL, 0, "rst_wlevel");
      checkOutput(S_ALMOST, 0, "rst_almost");
      checkOutput(S_OVF,    0, "rst_ovf");
    end

    // Fill from empty with the read pointer parked at 0.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput(S_WEN,    1, "fill_wen");
      checkOutput(S_WADDR,  k, "fill_waddr");
      checkOutput(S_WPTR,   fill_gray[k], "fill_wptr");
      checkOutput(S_WLEVEL, k, "fill_wlevel");
      checkOutput(S_ALMOST, (k >= 14) ? 1 : 0, "fill_almost");
    end

    // 17th request is refused by the internal guard while wfull is still 0.
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
    checkOutput(S_WEN,    0, "full_wen_blocked");
    checkOutput(S_WPTR,   5'b11000, "full_wptr");
    checkOutput(S_WLEVEL, 16, "full_wlevel");
    checkOutput(S_ALMOST, 1, "full_almost");

    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    checkOutput(S_OVF,    ovf_exp, "ovf_set");
    checkOutput(S_WPTR,   5'b11000, "ovf_wptr_held");
    checkOutput(S_WLEVEL, 16, "ovf_wlevel_held");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    checkOutput(S_OVF,    ovf_exp, "ovf_sticky");

    // Read pointer steps by one while full.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'b00001);
    checkOutput(S_WQ2,    0, "sync_wq2_e0");
    checkOutput(S_WLEVEL, 16, "sync_wlevel_e0");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'b00001);
    checkOutput(S_WQ2,    0, "sync_wq2_e1");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'b00001);
    checkOutput(S_WQ2,    1, "sync_wq2_e2");
    checkOutput(S_WLEVEL, 16, "sync_wlevel_e2");
    applyStimulus(1'b1, 1'b1, 1'b1, 5'b00001);
    checkOutput(S_WLEVEL, 15, "sync_wlevel_e3");
    checkOutput(S_ALMOST, 1, "sync_almost_e3");
    checkOutput(S_WEN,    0, "wfull_blocks_wen");
    applyStimulus(1'b1, 1'b1, 1'b0, 5'b00001);
    checkOutput(S_WEN,    1, "sync_write_accepted");
    checkOutput(S_WADDR,  0, "sync_write_waddr");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'b00001);
    checkOutput(S_WPTR,   5'b11001, "sync_write_wptr");
    checkOutput(S_WLEVEL, 16, "sync_write_wlevel");
    checkOutput(S_OVF,    ovf_exp, "ovf_still_sticky");

    // Clean reset, then 40 writes with the read pointer tracking.
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    checkOutput(S_WPTR,   0, "rst2_wptr");
    checkOutput(S_WQ2,    0, "rst2_wq2");
    checkOutput(S_WLEVEL, 0, "rst2_wlevel");
    checkOutput(S_OVF,    0, "rst2_ovf");
    for (int k = 0; k <= 40; k++) begin
      applyStimulus(1'b1, (k < 40) ? 1'b1 : 1'b0, 1'b0, gray(k));
      if (k < 40) checkOutput(S_WEN, 1, "wrap_wen");
      checkOutput(S_WADDR,  k % 16, "wrap_waddr");
      checkOutput(S_WPTR,   gray(k), "wrap_wptr");
      checkOutput(S_WLEVEL, (k < 3) ? k : 3, "wrap_wlevel");
      checkOutput(S_ALMOST, 0, "wrap_almost");
    end

    // Mid-operation reset at level 9.
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
      checkOutput(S_WADDR,  k, "mid_waddr");
      checkOutput(S_WLEVEL, k, "mid_wlevel");
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    checkOutput(S_WLEVEL, 9, "mid_wlevel9");
    checkOutput(S_WPTR,   5'b01101, "mid_wptr9");
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    checkOutput(S_WEN,    0, "midrst_wen");
    checkOutput(S_WADDR,  0, "midrst_waddr");
    checkOutput(S_WPTR,   0, "midrst_wptr");
    checkOutput(S_WQ2,    0, "midrst_wq2");
    checkOutput(S_WLEVEL, 0, "midrst_wlevel");
    checkOutput(S_ALMOST, 0, "midrst_almost");
    checkOutput(S_OVF,    0, "midrst_ovf");
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
    checkOutput(S_WEN,    1, "post_wen");
    checkOutput(S_WADDR,  0, "post_waddr");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    checkOutput(S_WPTR,   1, "post_wptr");
    checkOutput(S_WLEVEL, 1, "post_wlevel");

    @(negedge wclk);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
